// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame_reader block: command FSM states, default frame base
// address and a width helper.
package frame_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h3800_0000;

    // Smallest width w such that 2**w >= value.
    function automatic int unsigned clog2w(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH must be a power of 2 and at least 2.
// Simultaneous push and pop is accepted even when full.
module frame_reader_fifo
    import frame_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned CNT_W = clog2w(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = CNT_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] used_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            used_q <= used_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (used_q == '0);
    assign full     = (used_q == CNT_W'(DEPTH));
    assign count    = used_q;

endmodule

// File: rtl/frame_reader.sv
// Avalon-MM burst read master that streams a frame buffer out as Avalon-ST with sop/eop markers.
// Optional FRAME_READER_UNDERRUN_COUNT_EN adds a saturating stream underrun counter.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              BURST_COUNT   = 8,
    parameter int unsigned              BURST_WIDTH   = 4,
    parameter int unsigned              FRAME_BURSTS  = 65536,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = ADDRESS_WIDTH'(DEFAULT_BASE_ADDRESS),
    parameter int unsigned              FIFO_DEPTH    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] master_address,
    output logic                     master_read,
    output logic [BURST_WIDTH-1:0]   master_burstcount,
    output logic [DATA_WIDTH/8-1:0]  master_byteenable,
    input  logic                     master_waitrequest,
    input  logic [DATA_WIDTH-1:0]    master_readdata,
    input  logic                     master_readdatavalid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
`ifdef FRAME_READER_UNDERRUN_COUNT_EN
    ,
    output logic [31:0]              underrun_count
`endif
);

    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam int unsigned FRAME_WORDS = FRAME_BURSTS * BURST_COUNT;
    localparam int unsigned CNT_W       = clog2w(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W       = CNT_W + 1;
    localparam int unsigned BIDX_W      = clog2w(FRAME_BURSTS) + 1;
    localparam int unsigned WORD_W      = clog2w(FRAME_WORDS) + 1;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BIDX_W-1:0]        bidx_q, bidx_d;
    logic [CNT_W-1:0]         outst_q, outst_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic [CNT_W-1:0]         fifo_used;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     space_ok;
    logic                     accept;
    logic                     pop;
    logic                     frame_done;

    // Reserve FIFO room for every word in flight so readdatavalid can never overflow it.
    assign space_ok = ({1'b0, fifo_used} + {1'b0, outst_q} + SUM_W'(BURST_COUNT))
                      <= SUM_W'(FIFO_DEPTH);

    assign master_read       = (state_q == StIssue) && space_ok;
    assign master_address    = addr_q;
    assign master_burstcount = BURST_WIDTH'(BURST_COUNT);
    assign master_byteenable = '1;
    assign accept            = master_read && !master_waitrequest;
    assign busy              = (state_q != StIdle);

    assign out_valid         = !fifo_empty;
    assign pop               = out_valid && out_ready;
    assign frame_done        = pop && (word_q == WORD_W'(FRAME_WORDS - 1));
    assign out_startofpacket = out_valid && (word_q == '0);
    assign out_endofpacket   = out_valid && (word_q == WORD_W'(FRAME_WORDS - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bidx_d  = bidx_q;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StIssue;
                    addr_d  = BASE_ADDRESS;
                    bidx_d  = '0;
                end
            end
            StIssue: begin
                if (accept) begin
                    if (bidx_q == BIDX_W'(FRAME_BURSTS - 1)) begin
                        state_d = StDrain;
                        addr_d  = BASE_ADDRESS;
                        bidx_d  = '0;
                    end else begin
                        addr_d  = addr_q + ADDRESS_WIDTH'(BURST_COUNT * BYTES);
                        bidx_d  = bidx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (frame_done) begin
                    state_d = enable ? StIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outst_d = outst_q + (accept ? CNT_W'(BURST_COUNT) : '0) - CNT_W'(master_readdatavalid);
        word_d  = word_q;
        if (pop) begin
            word_d = frame_done ? '0 : word_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= BASE_ADDRESS;
            bidx_q  <= '0;
            outst_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bidx_q  <= bidx_d;
            outst_q <= outst_d;
            word_q  <= word_d;
        end
    end

    frame_reader_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (master_readdatavalid),
        .push_data (master_readdata),
        .pop       (pop),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_used)
    );

    overflow_check: assert property (@(posedge clk) disable iff (!reset)
        !(master_readdatavalid && fifo_full && !pop));

`ifdef FRAME_READER_UNDERRUN_COUNT_EN
    logic [31:0] underrun_q;

    // Waiting for the first word of a frame is expected latency, not an underrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_q <= '0;
        end else if (busy && out_ready && !out_valid && (word_q != '0) && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 1'b1;
        end
    end

    assign underrun_count = underrun_q;
`endif

endmodule
